// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: ibus payloads and state encoding.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Instruction bus request: valid plus word-aligned fetch address.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } ibus_req_t;

  // Instruction bus response: address accepted, data returned, data word.
  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } ibus_resp_t;

  // Fetch sequencer state encoding.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_ADDR = 2'd1;
  localparam fetch_state_t ST_DATA = 2'd2;
  localparam fetch_state_t ST_HOLD = 2'd3;

endpackage

// File: rtl/fetch_ctrl_perf_counter.sv
// Wrapping event counter.
// Ports: clk, resetn (async active-low), en (count this cycle), count (current value).
module perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  output logic [W-1:0] count
);

  // Natural modulo-2^W wrap on overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer between PC-select and the ibus.
// Ports: clk, resetn (async active-low); req_valid/req_addr/req_ready (fetch request);
// flush (redirect); ireq/iresp (instruction bus); out_valid/out_pc/out_instr/out_ready
// (to decode); busy (stall source); fetch_cnt/drop_cnt (performance counters).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [XLEN-1:0]  req_addr,
  output logic             req_ready,
  input  logic             flush,
  output ibus_req_t        ireq,
  input  ibus_resp_t       iresp,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  fetch_state_t    state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            fetch_inc;
  logic            drop_inc;
  logic            dropping;

  // A response is stale if a flush was seen earlier or arrives with it.
  assign dropping = drop_q | flush;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, capture and counter-enable logic.
  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    fetch_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ADDR;
          addr_d  = req_addr;
        end
      end
      ST_ADDR: begin
        // The request stays on the bus until accepted, even after a flush.
        if (iresp.addr_ok && iresp.data_ok) begin
          if (dropping) begin
            state_d  = ST_IDLE;
            drop_d   = 1'b0;
            drop_inc = 1'b1;
          end else begin
            state_d = ST_HOLD;
            instr_d = iresp.data;
          end
        end else if (iresp.addr_ok) begin
          state_d = ST_DATA;
          drop_d  = dropping;
        end else begin
          drop_d = dropping;
        end
      end
      ST_DATA: begin
        if (iresp.data_ok) begin
          if (dropping) begin
            state_d  = ST_IDLE;
            drop_d   = 1'b0;
            drop_inc = 1'b1;
          end else begin
            state_d = ST_HOLD;
            instr_d = iresp.data;
          end
        end else begin
          drop_d = dropping;
        end
      end
      ST_HOLD: begin
        // Flush wins over out_ready: buffer discarded, nothing counted.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (out_ready) begin
          state_d   = ST_IDLE;
          fetch_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // Output decodes of registered state.
  assign req_ready  = (state_q == ST_IDLE);
  assign ireq.valid = (state_q == ST_ADDR);
  assign ireq.addr  = addr_q;
  assign busy       = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign out_valid  = (state_q == ST_HOLD) && !flush;
  assign out_pc     = addr_q;
  assign out_instr  = instr_q;

  perf_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (fetch_inc),
    .count  (fetch_cnt)
  );

  perf_counter #(.W(CNT_W)) u_drop_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en     (drop_inc),
    .count  (drop_cnt)
  );

endmodule
